// File: rtl/case_mux_reg.sv
// Registered N-channel selector with a default arm for out-of-range selects,
// valid/ready handshake and a saturating illegal-select counter.
// Optional feature macro: CASE_MUX_HOLD_EN (illegal beats keep the previous out_data).
module case_mux_reg #(
    parameter int                 WIDTH       = 8,
    parameter int                 NUM_CH      = 4,
    parameter int                 SEL_W       = 3,
    parameter logic [WIDTH-1:0]   DEFAULT_VAL = '0,
    parameter int                 CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic [NUM_CH*WIDTH-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_illegal,
    output logic [CNT_W-1:0]          illegal_cnt,
    input  logic                      cnt_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_illegal_q, out_illegal_d;
    logic [CNT_W-1:0]   illegal_cnt_q, illegal_cnt_d;

    logic               accept;
    logic               sel_legal;
    logic [WIDTH-1:0]   sel_data;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Only exact matches against a real channel are legal, so an unknown
    // select falls through to the default arm.
    always_comb begin
        sel_legal = 1'b0;
        sel_data  = DEFAULT_VAL;
        for (int k = 0; k < NUM_CH; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_legal = 1'b1;
                sel_data  = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_illegal_d = out_illegal_q;
        illegal_cnt_d = illegal_cnt_q;

        if (accept) begin
            out_valid_d   = 1'b1;
            out_illegal_d = !sel_legal;
            if (sel_legal) begin
                out_data_d = sel_data;
            end else begin
`ifdef CASE_MUX_HOLD_EN
                out_data_d = out_data_q;
`else
                out_data_d = DEFAULT_VAL;
`endif
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // A clear wins over a simultaneous illegal accept; that beat is not counted.
        if (cnt_clr) begin
            illegal_cnt_d = '0;
        end else if (accept && !sel_legal && illegal_cnt_q != CNT_MAX) begin
            illegal_cnt_d = illegal_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= DEFAULT_VAL;
            out_illegal_q <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_illegal_q <= out_illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_illegal = out_illegal_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule
